// File: rtl/inst_queue_if.sv
// Fetch/decode-side bus of the instruction queue.
// master: fetch + decode side, slave: the queue itself.
interface inst_queue_if;
  logic [31:0] in_word0;
  logic [31:0] in_word1;
  logic [31:0] in_word2;
  logic [31:0] in_word3;
  logic        in_valid0;
  logic        in_valid1;
  logic        in_valid2;
  logic        in_valid3;
  logic [31:0] in_pc0;
  logic [31:0] in_pc1;
  logic [31:0] in_pc2;
  logic [31:0] in_pc3;
  logic        flush;
  logic [1:0]  deq_count;
  logic        fetch_stall;
  logic [31:0] out_inst0;
  logic [31:0] out_inst1;
  logic [31:0] out_pc0;
  logic [31:0] out_pc1;
  logic        out_valid0;
  logic        out_valid1;

  modport master (
    output in_word0, in_word1, in_word2, in_word3,
    output in_valid0, in_valid1, in_valid2, in_valid3,
    output in_pc0, in_pc1, in_pc2, in_pc3,
    output flush, deq_count,
    input  fetch_stall,
    input  out_inst0, out_inst1, out_pc0, out_pc1, out_valid0, out_valid1
  );

  modport slave (
    input  in_word0, in_word1, in_word2, in_word3,
    input  in_valid0, in_valid1, in_valid2, in_valid3,
    input  in_pc0, in_pc1, in_pc2, in_pc3,
    input  flush, deq_count,
    output fetch_stall,
    output out_inst0, out_inst1, out_pc0, out_pc1, out_valid0, out_valid1
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: compacts up to four fetched
// words per cycle into a circular FIFO and presents up to two to decode.
// Optional statistics (stall_cycles, peak_count) under INST_QUEUE_STATS_EN.
module inst_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset_n,
  inst_queue_if.slave    q
`ifdef INST_QUEUE_STATS_EN
  ,
  output logic [31:0]    stall_cycles,
  output logic [PTR_W:0] peak_count
`endif
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [3:0]       lane_valid;
  logic [31:0]      lane_word [4];
  logic [31:0]      lane_pc   [4];
  logic [2:0]       lane_off  [4];
  logic [2:0]       enq_n;
  logic             enq_en;
  logic [1:0]       deq_req;
  logic [1:0]       deq_d;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] head_p1;
  logic             stall;

  assign lane_valid = {q.in_valid3, q.in_valid2, q.in_valid1, q.in_valid0};
  assign lane_word  = '{q.in_word0, q.in_word1, q.in_word2, q.in_word3};
  assign lane_pc    = '{q.in_pc0, q.in_pc1, q.in_pc2, q.in_pc3};

  // Stall depends only on registered occupancy: room for 4 is not guaranteed.
  assign stall         = (count > CNT_W'(DEPTH - 4));
  assign q.fetch_stall = stall;
  assign enq_en        = ~stall & ~q.flush;

  // Compaction offsets: each valid lane lands after the valid lanes before it.
  always_comb begin
    enq_n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      lane_off[i] = enq_n;
      enq_n       = enq_n + 3'(lane_valid[i]);
    end
  end

  // Dequeue clamp (3 acts as 2, never more than held) and next occupancy.
  always_comb begin
    deq_req = (q.deq_count == 2'd3) ? 2'd2 : q.deq_count;
    deq_d   = (count < CNT_W'(deq_req)) ? 2'(count) : deq_req;
    if (q.flush) begin
      count_next = '0;
    end else begin
      count_next = count - CNT_W'(deq_d) + (enq_en ? CNT_W'(enq_n) : CNT_W'(0));
    end
  end

  // Pointer and occupancy registers; flush empties the queue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_d);
      tail  <= tail + (enq_en ? PTR_W'(enq_n) : PTR_W'(0));
      count <= count_next;
    end
  end

  // Storage write of valid lanes at tail onward, wrapping modulo DEPTH.
  always_ff @(posedge clock) begin
    if (enq_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_valid[i]) begin
          mem_inst[tail + PTR_W'(lane_off[i])] <= lane_word[i];
          mem_pc[tail + PTR_W'(lane_off[i])]   <= lane_pc[i];
        end
      end
    end
  end

  assign head_p1 = head + PTR_W'(1);

  // Decode view of head and head+1; invalid slots drive zero.
  assign q.out_valid0 = (count != '0);
  assign q.out_valid1 = (count >= CNT_W'(2));
  assign q.out_inst0  = q.out_valid0 ? mem_inst[head]    : 32'd0;
  assign q.out_pc0    = q.out_valid0 ? mem_pc[head]      : 32'd0;
  assign q.out_inst1  = q.out_valid1 ? mem_inst[head_p1] : 32'd0;
  assign q.out_pc1    = q.out_valid1 ? mem_pc[head_p1]   : 32'd0;

`ifdef INST_QUEUE_STATS_EN
  // Saturating stall counter and occupancy high-water mark; flush keeps them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      peak_count   <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (count_next > peak_count) begin
        peak_count <= count_next;
      end
    end
  end
`endif

endmodule
